// File: rtl/usb_line_state_monitor_pkg.sv
// Shared definitions for the USB line-state monitor: line-state codes,
// controller state enum and counter-sizing helpers.
package usb_line_pkg;

  // Line-state code is {D-, D+}, so J (P=1,N=0) is 1 and K is 2.
  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [1:0] LS_SE1 = 2'd3;

  typedef enum logic [1:0] {
    ST_POR       = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_BUS_RESET = 2'd2,
    ST_SUSPEND   = 2'd3
  } lsm_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/usb_line_state_monitor_sync.sv
// Receive-path conditioning: tx masking, two-flop synchroniser and a
// three-sample agreement filter that drives the registered line state.
module usb_line_sync
  import usb_line_pkg::*;
(
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       usb_p_rx_i,
  input  logic       usb_n_rx_i,
  input  logic       usb_tx_en_i,
  output logic [1:0] line_state_o
);

  logic [1:0] raw;
  logic [1:0] s1_q, s2_q, d1_q, d2_q, ls_q;

  // Our own transmission echoes on the receive pads; present it as idle.
  assign raw = usb_tx_en_i ? LS_J : {usb_n_rx_i, usb_p_rx_i};

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      s1_q <= LS_J;
      s2_q <= LS_J;
      d1_q <= LS_J;
      d2_q <= LS_J;
      ls_q <= LS_J;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      d1_q <= s2_q;
      d2_q <= d1_q;
      if ((s2_q == d1_q) && (d1_q == d2_q)) ls_q <= s2_q;
    end
  end

  assign line_state_o = ls_q;

endmodule

// File: rtl/usb_line_state_monitor.sv
// USB line-state monitor: classifies the filtered bus state and sequences
// power-on reset, bus reset, suspend and resume for the bootloader core.
//
// state     | meaning
// ----------+---------------------------------------------------------
// POR       | power-on hold, usb_reset high, line activity ignored
// ACTIVE    | normal operation, watching for long SE0 or long idle J
// BUS_RESET | SE0 qualified, usb_reset high until hold time after SE0
// SUSPEND   | idle J qualified, waiting for K (resume) or SE0 (reset)
module usb_line_state_monitor
  import usb_line_pkg::*;
#(
  parameter int POR_CYCLES        = 4096,
  parameter int SE0_RESET_CYCLES  = 120,
  parameter int RESET_HOLD_CYCLES = 480,
  parameter int SUSPEND_CYCLES    = 144000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  input  logic       usb_tx_en,
  output logic [1:0] line_state,
  output logic       usb_reset,
  output logic       suspended,
  output logic       resume_detect,
  output logic [7:0] bus_reset_count
);

  localparam int DET_W = cnt_width(max_int(SE0_RESET_CYCLES, SUSPEND_CYCLES));
  localparam int TMR_W = cnt_width(max_int(POR_CYCLES, RESET_HOLD_CYCLES));

  localparam logic [DET_W-1:0] SE0_TC  = DET_W'(SE0_RESET_CYCLES - 1);
  localparam logic [DET_W-1:0] IDLE_TC = DET_W'(SUSPEND_CYCLES - 1);
  localparam logic [DET_W-1:0] DET_MAX = '1;
  localparam logic [TMR_W-1:0] POR_TC  = TMR_W'(POR_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_TC = TMR_W'(RESET_HOLD_CYCLES - 1);

  logic [1:0]       ls;
  logic [DET_W-1:0] se0_cnt_q, se0_cnt_d;
  logic [DET_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [TMR_W-1:0] timer_q;
  lsm_state_e       state_q;
  logic             usb_reset_q, suspended_q, resume_q;
  logic [7:0]       brc_q;
  logic             se0_hit, idle_hit;

  usb_line_sync u_sync (
    .clk_48mhz   (clk_48mhz),
    .reset       (reset),
    .usb_p_rx_i  (usb_p_rx),
    .usb_n_rx_i  (usb_n_rx),
    .usb_tx_en_i (usb_tx_en),
    .line_state_o(ls)
  );

  always_comb begin
    se0_cnt_d  = '0;
    idle_cnt_d = '0;
    if (ls == LS_SE0)
      se0_cnt_d = (se0_cnt_q == DET_MAX) ? se0_cnt_q : se0_cnt_q + DET_W'(1);
    if ((ls == LS_J) && !usb_tx_en)
      idle_cnt_d = (idle_cnt_q == DET_MAX) ? idle_cnt_q : idle_cnt_q + DET_W'(1);
  end

  // >= rather than == so a run that started during POR still qualifies.
  assign se0_hit  = (ls == LS_SE0) && (se0_cnt_q >= SE0_TC);
  assign idle_hit = (ls == LS_J) && !usb_tx_en && (idle_cnt_q >= IDLE_TC);

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      se0_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      se0_cnt_q  <= se0_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q     <= ST_POR;
      timer_q     <= POR_TC;
      usb_reset_q <= 1'b1;
      suspended_q <= 1'b0;
      resume_q    <= 1'b0;
      brc_q       <= 8'd0;
    end else begin
      resume_q <= 1'b0;
      case (state_q)
        ST_POR: begin
          if (timer_q == '0) begin
            state_q     <= ST_ACTIVE;
            usb_reset_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (se0_hit) begin
            state_q     <= ST_BUS_RESET;
            usb_reset_q <= 1'b1;
            timer_q     <= HOLD_TC;
            brc_q       <= brc_q + 8'd1;
          end else if (idle_hit) begin
            state_q     <= ST_SUSPEND;
            suspended_q <= 1'b1;
          end
        end
        ST_BUS_RESET: begin
          // Hold time counts down only once SE0 has gone; SE0 reloads it.
          if (ls == LS_SE0) begin
            timer_q <= HOLD_TC;
          end else if (timer_q == '0) begin
            state_q     <= ST_ACTIVE;
            usb_reset_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_SUSPEND: begin
          if (ls == LS_K) begin
            state_q     <= ST_ACTIVE;
            suspended_q <= 1'b0;
            resume_q    <= 1'b1;
          end else if (se0_hit) begin
            state_q     <= ST_BUS_RESET;
            suspended_q <= 1'b0;
            usb_reset_q <= 1'b1;
            timer_q     <= HOLD_TC;
            brc_q       <= brc_q + 8'd1;
          end
        end
        default: begin
          state_q     <= ST_POR;
          timer_q     <= POR_TC;
          usb_reset_q <= 1'b1;
          suspended_q <= 1'b0;
        end
      endcase
    end
  end

  assign line_state      = ls;
  assign usb_reset       = usb_reset_q;
  assign suspended       = suspended_q;
  assign resume_detect   = resume_q;
  assign bus_reset_count = brc_q;

endmodule

// File: tb/tb_usb_line_state_monitor.sv
// Bench for usb_line_state_monitor: output changes are logged as timed events
// and matched against events the stimulus predicts.
module tb_usb_line_state_monitor;

  localparam logic [1:0] SE0 = 2'd0;
  localparam logic [1:0] J   = 2'd1;
  localparam logic [1:0] K   = 2'd2;
  localparam logic [1:0] SE1 = 2'd3;

  // Signal ids used in event words.
  localparam int S_RST = 0, S_SUSP = 1, S_RES = 2, S_LS = 3, S_CNT = 4;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic       usb_p_rx, usb_n_rx, usb_tx_en;
  logic [1:0] line_state;
  logic       usb_reset, suspended, resume_detect;
  logic [7:0] bus_reset_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] e, o;

  logic       p_rst, p_susp, p_res;
  logic [1:0] p_ls;
  logic [7:0] p_cnt;

  usb_line_state_monitor #(
    .POR_CYCLES(16), .SE0_RESET_CYCLES(120), .RESET_HOLD_CYCLES(32), .SUSPEND_CYCLES(1000)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .usb_p_rx(usb_p_rx), .usb_n_rx(usb_n_rx),
    .usb_tx_en(usb_tx_en), .line_state(line_state), .usb_reset(usb_reset),
    .suspended(suspended), .resume_detect(resume_detect), .bus_reset_count(bus_reset_count)
  );

  always #5 clk_48mhz = ~clk_48mhz;
  always @(posedge clk_48mhz) cyc <= cyc + 1;

  function automatic logic [31:0] ev(input int sig, input int val, input int c);
    return {sig[3:0], val[7:0], c[19:0]};
  endfunction

  // Negedge monitor: log every output change with the edge count it followed.
  always @(negedge clk_48mhz) begin
    if (mon_en) begin
      if (usb_reset !== p_rst)         obs_q.push_back(ev(S_RST, int'(usb_reset), cyc));
      if (suspended !== p_susp)        obs_q.push_back(ev(S_SUSP, int'(suspended), cyc));
      if (resume_detect !== p_res)     obs_q.push_back(ev(S_RES, int'(resume_detect), cyc));
      if (line_state !== p_ls)         obs_q.push_back(ev(S_LS, int'(line_state), cyc));
      if (bus_reset_count !== p_cnt)   obs_q.push_back(ev(S_CNT, int'(bus_reset_count), cyc));
    end
    p_rst  = usb_reset;
    p_susp = suspended;
    p_res  = resume_detect;
    p_ls   = line_state;
    p_cnt  = bus_reset_count;
  end

  task automatic drive(input logic [1:0] ls, input logic tx);
    usb_p_rx  = ls[0];
    usb_n_rx  = ls[1];
    usb_tx_en = tx;
  endtask

  // Returns #1 after the posedge at which cyc reaches c.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_48mhz);
      #1;
    end
  endtask

  task automatic test_reset;
    int rc;
    reset = 1'b1;
    drive(J, 1'b0);
    repeat (5) @(posedge clk_48mhz);
    #1;
    n_checks++; if (usb_reset !== 1'b1) begin n_fail++; $display("FAIL reset usb_reset: got %b want 1", usb_reset); end
    n_checks++; if (suspended !== 1'b0) begin n_fail++; $display("FAIL reset suspended: got %b want 0", suspended); end
    n_checks++; if (resume_detect !== 1'b0) begin n_fail++; $display("FAIL reset resume_detect: got %b want 0", resume_detect); end
    n_checks++; if (line_state !== J) begin n_fail++; $display("FAIL reset line_state: got %0d want 1", line_state); end
    n_checks++; if (bus_reset_count !== 8'd0) begin n_fail++; $display("FAIL reset bus_reset_count: got %0d want 0", bus_reset_count); end
    reset = 1'b0;
    rc = cyc;
    mon_en = 1'b1;
    exp_q.push_back(ev(S_RST, 0, rc + 16));
    wait_until(rc + 25);
    n_checks++; if (suspended !== 1'b0) begin n_fail++; $display("FAIL por suspended: got %b want 0", suspended); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL por event: got none want sig=%0d val=%0d cyc=%0d", e[31:28], e[27:20], e[19:0]); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL por event: got sig=%0d val=%0d cyc=%0d want sig=%0d val=%0d cyc=%0d", o[31:28], o[27:20], o[19:0], e[31:28], e[27:20], e[19:0]); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL por extra events: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_bus_reset;
    int c0, c1;
    c0 = cyc;
    drive(SE0, 1'b0);
    exp_q.push_back(ev(S_LS, 0, c0 + 5));
    exp_q.push_back(ev(S_RST, 1, c0 + 125));
    exp_q.push_back(ev(S_CNT, 1, c0 + 125));
    wait_until(c0 + 200);
    c1 = cyc;
    drive(J, 1'b0);
    exp_q.push_back(ev(S_LS, 1, c1 + 5));
    exp_q.push_back(ev(S_RST, 0, c1 + 37));
    wait_until(c1 + 45);
    n_checks++; if (bus_reset_count !== 8'd1) begin n_fail++; $display("FAIL bus_reset count: got %0d want 1", bus_reset_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL bus_reset event: got none want sig=%0d val=%0d cyc=%0d", e[31:28], e[27:20], e[19:0]); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL bus_reset event: got sig=%0d val=%0d cyc=%0d want sig=%0d val=%0d cyc=%0d", o[31:28], o[27:20], o[19:0], e[31:28], e[27:20], e[19:0]); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bus_reset extra events: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_hold_restart;
    int h;
    h = cyc;
    drive(SE0, 1'b0);
    exp_q.push_back(ev(S_LS, 0, h + 5));
    exp_q.push_back(ev(S_RST, 1, h + 125));
    exp_q.push_back(ev(S_CNT, 2, h + 125));
    wait_until(h + 130); drive(J, 1'b0);
    exp_q.push_back(ev(S_LS, 1, h + 135));
    wait_until(h + 140); drive(SE0, 1'b0);
    exp_q.push_back(ev(S_LS, 0, h + 145));
    wait_until(h + 150); drive(J, 1'b0);
    exp_q.push_back(ev(S_LS, 1, h + 155));
    exp_q.push_back(ev(S_RST, 0, h + 187));
    wait_until(h + 195);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL hold_restart event: got none want sig=%0d val=%0d cyc=%0d", e[31:28], e[27:20], e[19:0]); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL hold_restart event: got sig=%0d val=%0d cyc=%0d want sig=%0d val=%0d cyc=%0d", o[31:28], o[27:20], o[19:0], e[31:28], e[27:20], e[19:0]); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL hold_restart extra events: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_short_se0_glitch;
    int c, g;
    c = cyc;
    drive(SE0, 1'b0);
    exp_q.push_back(ev(S_LS, 0, c + 5));
    wait_until(c + 119); drive(J, 1'b0);
    exp_q.push_back(ev(S_LS, 1, c + 124));
    wait_until(c + 130);
    for (int i = 0; i < 5; i++) begin
      drive(K, 1'b0);
      wait_until(cyc + 2);
      drive(J, 1'b0);
      wait_until(cyc + 6);
    end
    // SE1 between two sub-threshold SE0 runs must clear the SE0 count.
    g = cyc;
    drive(SE0, 1'b0);
    exp_q.push_back(ev(S_LS, 0, g + 5));
    wait_until(g + 100); drive(SE1, 1'b0);
    exp_q.push_back(ev(S_LS, 3, g + 105));
    wait_until(g + 110); drive(SE0, 1'b0);
    exp_q.push_back(ev(S_LS, 0, g + 115));
    wait_until(g + 210); drive(J, 1'b0);
    exp_q.push_back(ev(S_LS, 1, g + 215));
    wait_until(g + 220);
    n_checks++; if (bus_reset_count !== 8'd2) begin n_fail++; $display("FAIL glitch count: got %0d want 2", bus_reset_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL glitch event: got none want sig=%0d val=%0d cyc=%0d", e[31:28], e[27:20], e[19:0]); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL glitch event: got sig=%0d val=%0d cyc=%0d want sig=%0d val=%0d cyc=%0d", o[31:28], o[27:20], o[19:0], e[31:28], e[27:20], e[19:0]); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch extra events: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_suspend_resume;
    int t0, k0;
    t0 = cyc;
    drive(SE0, 1'b0);
    exp_q.push_back(ev(S_LS, 0, t0 + 5));
    wait_until(t0 + 10); drive(J, 1'b0);
    exp_q.push_back(ev(S_LS, 1, t0 + 15));
    exp_q.push_back(ev(S_SUSP, 1, t0 + 1015));
    wait_until(t0 + 1020);
    n_checks++; if (suspended !== 1'b1) begin n_fail++; $display("FAIL suspend level: got %b want 1", suspended); end
    k0 = cyc;
    drive(K, 1'b0);
    exp_q.push_back(ev(S_LS, 2, k0 + 5));
    exp_q.push_back(ev(S_SUSP, 0, k0 + 6));
    exp_q.push_back(ev(S_RES, 1, k0 + 6));
    exp_q.push_back(ev(S_RES, 0, k0 + 7));
    wait_until(k0 + 10); drive(J, 1'b0);
    exp_q.push_back(ev(S_LS, 1, k0 + 15));
    wait_until(k0 + 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL suspend event: got none want sig=%0d val=%0d cyc=%0d", e[31:28], e[27:20], e[19:0]); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL suspend event: got sig=%0d val=%0d cyc=%0d want sig=%0d val=%0d cyc=%0d", o[31:28], o[27:20], o[19:0], e[31:28], e[27:20], e[19:0]); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL suspend extra events: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_tx_masking;
    int t0;
    t0 = cyc;
    drive(K, 1'b1);
    wait_until(t0 + 2000);
    n_checks++; if (suspended !== 1'b0) begin n_fail++; $display("FAIL tx suspended: got %b want 0", suspended); end
    drive(J, 1'b0);
    wait_until(t0 + 2010);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL tx extra events: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid;
    int m0, r0;
    m0 = cyc;
    drive(SE0, 1'b0);
    exp_q.push_back(ev(S_LS, 0, m0 + 5));
    exp_q.push_back(ev(S_RST, 1, m0 + 125));
    exp_q.push_back(ev(S_CNT, 3, m0 + 125));
    wait_until(m0 + 150);
    r0 = cyc;
    reset = 1'b1;
    wait_until(r0 + 1);
    reset = 1'b0;
    drive(J, 1'b0);
    exp_q.push_back(ev(S_LS, 1, r0 + 1));
    exp_q.push_back(ev(S_CNT, 0, r0 + 1));
    exp_q.push_back(ev(S_RST, 0, r0 + 17));
    wait_until(r0 + 25);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL reset_mid event: got none want sig=%0d val=%0d cyc=%0d", e[31:28], e[27:20], e[19:0]); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL reset_mid event: got sig=%0d val=%0d cyc=%0d want sig=%0d val=%0d cyc=%0d", o[31:28], o[27:20], o[19:0], e[31:28], e[27:20], e[19:0]); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_mid extra events: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_count_wrap;
    int w;
    for (int i = 0; i < 256; i++) begin
      w = cyc;
      drive(SE0, 1'b0);
      exp_q.push_back(ev(S_LS, 0, w + 5));
      exp_q.push_back(ev(S_RST, 1, w + 125));
      exp_q.push_back(ev(S_CNT, (i + 1) % 256, w + 125));
      wait_until(w + 122); drive(J, 1'b0);
      exp_q.push_back(ev(S_LS, 1, w + 127));
      exp_q.push_back(ev(S_RST, 0, w + 159));
      wait_until(w + 165);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n_checks++;
        if (obs_q.size() == 0) begin n_fail++; $display("FAIL wrap[%0d] event: got none want sig=%0d val=%0d cyc=%0d", i, e[31:28], e[27:20], e[19:0]); end
        else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL wrap[%0d] event: got sig=%0d val=%0d cyc=%0d want sig=%0d val=%0d cyc=%0d", i, o[31:28], o[27:20], o[19:0], e[31:28], e[27:20], e[19:0]); end end
      end
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL wrap[%0d] extra events: got %0d want 0", i, obs_q.size()); obs_q.delete(); end
    end
    n_checks++; if (bus_reset_count !== 8'd0) begin n_fail++; $display("FAIL wrap count: got %0d want 0", bus_reset_count); end
  endtask

  initial begin
    test_reset;
    test_bus_reset;
    test_hold_restart;
    test_short_se0_glitch;
    test_suspend_resume;
    test_tx_masking;
    test_reset_mid;
    test_count_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
